// File: rtl/lcd_char_writer_if.sv
// Byte request handshake between the console/bus logic and the LCD character writer.
interface lcd_char_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_ready;

  modport master (output in_valid, in_data, in_rs, input in_ready);
  modport slave  (input in_valid, in_data, in_rs, output in_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit writer: power-on nibble init, then valid/ready byte writes sent as two nibbles.
// All intervals are given in ns and converted to cycle counts at elaboration.
module lcd_char_writer #(
  parameter int unsigned CLK_PERIOD_NS   = 20,
  parameter int unsigned T_POWERUP_NS    = 15000000,
  parameter int unsigned T_INIT1_NS      = 4100000,
  parameter int unsigned T_INIT2_NS      = 100000,
  parameter int unsigned T_INIT3_NS      = 40000,
  parameter int unsigned T_SETUP_NS      = 40,
  parameter int unsigned T_EN_NS         = 240,
  parameter int unsigned T_NIBBLE_GAP_NS = 1000,
  parameter int unsigned T_CMD_NS        = 40000,
  parameter int unsigned T_CLEAR_NS      = 1640000
) (
  input  logic                clk,
  input  logic                rst,
  lcd_char_writer_if.slave    bus,
  output logic                init_done,
  output logic                lcd_e,
  output logic [3:0]          lcd_nibble,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                disable_flash
);

  function automatic int unsigned to_cycles(input int unsigned t_ns);
    int unsigned n;
    n = (t_ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned N_POWERUP = to_cycles(T_POWERUP_NS);
  localparam int unsigned N_INIT1   = to_cycles(T_INIT1_NS);
  localparam int unsigned N_INIT2   = to_cycles(T_INIT2_NS);
  localparam int unsigned N_INIT3   = to_cycles(T_INIT3_NS);
  localparam int unsigned N_SETUP   = to_cycles(T_SETUP_NS);
  localparam int unsigned N_EN      = to_cycles(T_EN_NS);
  localparam int unsigned N_GAP     = to_cycles(T_NIBBLE_GAP_NS);
  localparam int unsigned N_CMD     = to_cycles(T_CMD_NS);
  localparam int unsigned N_CLEAR   = to_cycles(T_CLEAR_NS);
  localparam int unsigned N_MAX     = max_u(max_u(max_u(N_POWERUP, N_INIT1), max_u(N_INIT2, N_INIT3)),
                                            max_u(max_u(N_SETUP, N_EN), max_u(max_u(N_GAP, N_CMD), N_CLEAR)));
  localparam int unsigned CNT_W     = $clog2(N_MAX) + 1;

  typedef enum logic [3:0] {
    PWR_WAIT, I_SETUP, I_PULSE, I_WAIT, IDLE,
    HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, EXEC
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         step_q, step_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               e_d, lrs_d, ready_q, ready_d, done_d;
  logic [3:0]         nib_d;
  logic               expired;
  logic               long_exec;

  // A timed state lasts exactly n cycles when entered with n-1 loaded.
  function automatic logic [CNT_W-1:0] load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] step);
    case (step)
      2'd0:    return load(N_INIT1);
      2'd1:    return load(N_INIT2);
      default: return load(N_INIT3);
    endcase
  endfunction

  // Clear (0x01) and Home (0x02/0x03) commands need the long execution wait.
  assign long_exec = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;
    rs_d    = rs_q;
    e_d     = 1'b0;
    nib_d   = lcd_nibble;
    lrs_d   = lcd_rs;
    ready_d = 1'b0;
    done_d  = init_done;
    expired = (cnt_q == '0);
    if (!expired) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      PWR_WAIT: if (expired) begin state_d = I_SETUP;  cnt_d = load(N_SETUP); end
      I_SETUP:  if (expired) begin state_d = I_PULSE;  cnt_d = load(N_EN);    end
      I_PULSE:  if (expired) begin state_d = I_WAIT;   cnt_d = init_wait(step_q); end
      I_WAIT: begin
        if (expired) begin
          if (step_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = I_SETUP;
            cnt_d   = load(N_SETUP);
          end
        end
      end
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          data_d  = bus.in_data;
          rs_d    = bus.in_rs;
          state_d = HI_SETUP;
          cnt_d   = load(N_SETUP);
        end
      end
      HI_SETUP: if (expired) begin state_d = HI_PULSE; cnt_d = load(N_EN);    end
      HI_PULSE: if (expired) begin state_d = GAP;      cnt_d = load(N_GAP);   end
      GAP:      if (expired) begin state_d = LO_SETUP; cnt_d = load(N_SETUP); end
      LO_SETUP: if (expired) begin state_d = LO_PULSE; cnt_d = load(N_EN);    end
      LO_PULSE: if (expired) begin state_d = EXEC; cnt_d = long_exec ? load(N_CLEAR) : load(N_CMD); end
      EXEC:     if (expired) state_d = IDLE;
      default:  state_d = PWR_WAIT;
    endcase

    // Registered outputs follow the state being entered; nibble/rs hold otherwise.
    case (state_d)
      I_SETUP: begin
        nib_d = (step_d == 2'd3) ? 4'h2 : 4'h3;
        lrs_d = 1'b0;
      end
      HI_SETUP: begin
        nib_d = data_d[7:4];
        lrs_d = rs_d;
      end
      LO_SETUP: nib_d = data_d[3:0];
      I_PULSE, HI_PULSE, LO_PULSE: e_d = 1'b1;
      IDLE: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR_WAIT;
      cnt_q      <= load(N_POWERUP);
      step_q     <= 2'd0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_nibble <= 4'h0;
      lcd_rs     <= 1'b0;
      ready_q    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      lcd_e      <= e_d;
      lcd_nibble <= nib_d;
      lcd_rs     <= lrs_d;
      ready_q    <= ready_d;
      init_done  <= done_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign lcd_rw         = 1'b0;
  assign disable_flash  = 1'b1;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: init timing, byte strobes, exec waits, back-to-back and reset.
module tb_lcd_char_writer;

  localparam int N_SETUP = 4;
  localparam int N_EN    = 24;
  localparam int N_GAP   = 10;
  localparam int N_CMD   = 30;
  localparam int N_CLEAR = 100;
  localparam int BUDGET  = 1000;
  localparam int S_E = 0, S_DONE = 1, S_RDY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, lcd_e, lcd_rs, lcd_rw, disable_flash;
  logic [3:0] lcd_nibble;
  int         n_cmp = 0;
  int         n_err = 0;

  lcd_char_writer_if bus ();

  lcd_char_writer #(
    .CLK_PERIOD_NS(10), .T_POWERUP_NS(1000), .T_INIT1_NS(500), .T_INIT2_NS(200),
    .T_INIT3_NS(100), .T_SETUP_NS(40), .T_EN_NS(240), .T_NIBBLE_GAP_NS(100),
    .T_CMD_NS(300), .T_CLEAR_NS(1000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done), .lcd_e(lcd_e),
    .lcd_nibble(lcd_nibble), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .disable_flash(disable_flash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_E:     return lcd_e;
      S_DONE:  return init_done;
      default: return bus.in_ready;
    endcase
  endfunction

  // Counts falling edges until the selected signal reaches lvl (bounded).
  task automatic wait_for(input int sel, input logic lvl, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_init();
    int n;
    logic [3:0] exp_nib;
    int exp_low[3] = '{54, 24, 14};
    wait_for(S_E, 1'b1, n);
    check("init_powerup_to_e", n, 104);
    for (int i = 0; i < 4; i++) begin
      exp_nib = (i == 3) ? 4'h2 : 4'h3;
      check($sformatf("init_nib%0d", i), lcd_nibble, exp_nib);
      check($sformatf("init_rs%0d", i), lcd_rs, 0);
      check($sformatf("init_ready%0d", i), bus.in_ready, 0);
      check($sformatf("init_done_early%0d", i), init_done, 0);
      wait_for(S_E, 1'b0, n);
      check($sformatf("init_pulse%0d", i), n, N_EN);
      if (i < 3) begin
        wait_for(S_E, 1'b1, n);
        check($sformatf("init_low%0d", i), n, exp_low[i]);
      end
    end
    wait_for(S_DONE, 1'b1, n);
    check("init_final_wait", n, 10);
    check("init_ready_at_done", bus.in_ready, 1);
  endtask

  // Checks both strobes of one accepted byte; starts on the falling edge after acceptance.
  task automatic check_strobe(input logic [7:0] d, input logic rs, input int exec_n);
    int n;
    wait_for(S_E, 1'b1, n);
    check("hi_setup", n, N_SETUP);
    check("hi_nibble", lcd_nibble, d[7:4]);
    check("hi_rs", lcd_rs, rs);
    wait_for(S_E, 1'b0, n);
    check("hi_pulse", n, N_EN);
    wait_for(S_E, 1'b1, n);
    check("gap_plus_setup", n, N_GAP + N_SETUP);
    check("lo_nibble", lcd_nibble, d[3:0]);
    check("lo_rs", lcd_rs, rs);
    wait_for(S_E, 1'b0, n);
    check("lo_pulse", n, N_EN);
    wait_for(S_RDY, 1'b1, n);
    check("exec_len", n, exec_n);
    check("held_nibble", lcd_nibble, d[3:0]);
    check("held_rs", lcd_rs, rs);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rs, input int exec_n);
    int n;
    wait_for(S_RDY, 1'b1, n);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_rs    = rs;
    @(negedge clk);
    check("accept_drops_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    check_strobe(d, rs, exec_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rises;
    logic [7:0] cmd_d[6]  = '{8'h01, 8'h02, 8'h03, 8'h28, 8'h04, 8'h01};
    logic       cmd_rs[6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    int         cmd_ex[6] = '{N_CLEAR, N_CLEAR, N_CLEAR, N_CMD, N_CMD, N_CMD};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_rs    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_e", lcd_e, 0);
    check("rst_nibble", lcd_nibble, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_flash", disable_flash, 1);
    check("rst_ready", bus.in_ready, 0);
    check("rst_done", init_done, 0);

    // Request held during init must wait for init_done.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    bus.in_rs    = 1'b1;
    rst = 1'b0;
    run_init();
    @(negedge clk);
    check("early_accept", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    check_strobe(8'h41, 1'b1, N_CMD);

    send_byte(8'h48, 1'b1, N_CMD);
    for (int i = 0; i < 6; i++) send_byte(cmd_d[i], cmd_rs[i], cmd_ex[i]);

    // Back-to-back: valid stays high across both bytes.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    bus.in_rs    = 1'b1;
    @(negedge clk);
    check("b2b_first_accept", bus.in_ready, 0);
    bus.in_data = 8'h42;
    check_strobe(8'h41, 1'b1, N_CMD);
    @(negedge clk);
    check("b2b_second_accept", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    check_strobe(8'h42, 1'b1, N_CMD);
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_e) rises++;
    end
    check("b2b_no_extra_strobe", rises, 0);
    check("b2b_ready_idle", bus.in_ready, 1);

    // Reset in the middle of the high-nibble pulse.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_rs    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_for(S_E, 1'b1, rises);
    check("mid_pulse_e_high", lcd_e, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_e", lcd_e, 0);
    check("midrst_done", init_done, 0);
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_flash", disable_flash, 1);
    rst = 1'b0;
    run_init();
    send_byte(8'h28, 1'b0, N_CMD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
